// File: rtl/ptmch_cfg.sv
// Serial configuration slave for the pattern-match trigger block: 32-bit frames
// (8-bit header + 24-bit data) write or read trigger address windows and enables.
module ptmch_cfg #(
  parameter logic [3:0]  P_WR_OP    = 4'hA,
  parameter logic [3:0]  P_RD_OP    = 4'h5,
  parameter logic [23:0] P_LOW_RST  = 24'h000000,
  parameter logic [23:0] P_HIGH_RST = 24'hFFFFFF,
  parameter logic [4:0]  P_EN_RST   = 5'h1F
) (
  input  logic        RESET_N,
  input  logic        SPI_CLK,
  input  logic        CFG_CS_N,
  input  logic        CFG_MOSI,
  output logic        CFG_MISO,
  output logic [23:0] PRGEXCT_LOW_ADDR,
  output logic [23:0] PRGEXCT_HIGH_ADDR,
  output logic [23:0] RDSTAT_LOW_ADDR,
  output logic [23:0] RDSTAT_HIGH_ADDR,
  output logic [23:0] BLKERS_LOW_ADDR,
  output logic [23:0] BLKERS_HIGH_ADDR,
  output logic [23:0] PDREAD_LOW_ADDR,
  output logic [23:0] PDREAD_HIGH_ADDR,
  output logic [23:0] WRSTAT_LOW_ADDR,
  output logic [23:0] WRSTAT_HIGH_ADDR,
  output logic [4:0]  TRG_EN,
  output logic        CFG_WR_STB,
  output logic [7:0]  ERR_CNT
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int         N_ADDR    = 10;
  localparam logic [3:0] IDX_EN    = 4'd10;
  localparam logic [3:0] IDX_ERR   = 4'd11;

  logic [1:0]  state;
  logic [5:0]  bit_cnt;
  logic [7:0]  hdr_sr;
  logic [23:0] data_sr;
  logic [23:0] miso_sr;
  logic        wr_ok;
  logic        rd_ok;
  logic [23:0] addr_q [N_ADDR];

  // Header/data as they will read once this edge's bit is shifted in.
  logic [7:0]  hdr_next;
  logic [23:0] data_next;
  logic [3:0]  nx_op;
  logic [3:0]  nx_idx;
  logic        hdr_wr;
  logic        hdr_rd;
  logic [23:0] rd_val;
  logic        hdr_edge;
  logic        commit;
  logic        err_inc;
  logic        err_clr;

  assign hdr_next  = {hdr_sr[6:0], CFG_MOSI};
  assign data_next = {data_sr[22:0], CFG_MOSI};
  assign nx_op     = hdr_next[7:4];
  assign nx_idx    = hdr_next[3:0];
  assign hdr_wr    = (nx_op == P_WR_OP) && (nx_idx <= IDX_ERR);
  assign hdr_rd    = (nx_op == P_RD_OP) && (nx_idx <= IDX_ERR);

  assign hdr_edge  = !CFG_CS_N && (state == S_HDR)  && (bit_cnt == 6'd7);
  assign commit    = !CFG_CS_N && (state == S_DATA) && (bit_cnt == 6'd31) && wr_ok;
  assign err_clr   = commit && (hdr_sr[3:0] == IDX_ERR);
  assign err_inc   = (CFG_CS_N && (bit_cnt != 6'd0) && (bit_cnt < 6'd32)) ||
                     (hdr_edge && !(hdr_wr || hdr_rd));

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < N_ADDR; i++) begin
      if (nx_idx == 4'(i)) rd_val = addr_q[i];
    end
    if (nx_idx == IDX_EN)  rd_val = {19'd0, TRG_EN};
    if (nx_idx == IDX_ERR) rd_val = {16'd0, ERR_CNT};
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge SPI_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      hdr_sr   <= '0;
      data_sr  <= '0;
      miso_sr  <= '0;
      wr_ok    <= 1'b0;
      rd_ok    <= 1'b0;
      CFG_MISO <= 1'b0;
    end else if (CFG_CS_N) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      wr_ok    <= 1'b0;
      rd_ok    <= 1'b0;
      CFG_MISO <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state   <= S_HDR;
          bit_cnt <= 6'd1;
          hdr_sr  <= {7'd0, CFG_MOSI};
        end
        S_HDR: begin
          hdr_sr  <= hdr_next;
          bit_cnt <= bit_cnt + 6'd1;
          if (bit_cnt == 6'd7) begin
            state    <= S_DATA;
            wr_ok    <= hdr_wr;
            rd_ok    <= hdr_rd;
            miso_sr  <= hdr_rd ? rd_val : 24'd0;
            CFG_MISO <= hdr_rd && rd_val[23];
          end
        end
        S_DATA: begin
          data_sr  <= data_next;
          bit_cnt  <= bit_cnt + 6'd1;
          miso_sr  <= miso_sr << 1;
          CFG_MISO <= rd_ok && miso_sr[22];
          if (bit_cnt == 6'd31) begin
            state    <= S_DONE;
            CFG_MISO <= 1'b0;
          end
        end
        S_DONE:  ;
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the window registers are outputs with defined power-up values, so the whole array is reset.
  always_ff @(posedge SPI_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < N_ADDR; i++) addr_q[i] <= (i % 2 == 0) ? P_LOW_RST : P_HIGH_RST;
      TRG_EN     <= P_EN_RST;
      CFG_WR_STB <= 1'b0;
    end else begin
      CFG_WR_STB <= commit;
      if (commit) begin
        for (int i = 0; i < N_ADDR; i++) begin
          if (hdr_sr[3:0] == 4'(i)) addr_q[i] <= data_next;
        end
        if (hdr_sr[3:0] == IDX_EN) TRG_EN <= data_next[4:0];
      end
    end
  end

  always_ff @(posedge SPI_CLK or negedge RESET_N) begin
    if (!RESET_N)                           ERR_CNT <= '0;
    else if (err_clr)                       ERR_CNT <= '0;
    else if (err_inc && ERR_CNT != 8'hFF)   ERR_CNT <= ERR_CNT + 8'd1;
  end

  assign PRGEXCT_LOW_ADDR  = addr_q[0];
  assign PRGEXCT_HIGH_ADDR = addr_q[1];
  assign RDSTAT_LOW_ADDR   = addr_q[2];
  assign RDSTAT_HIGH_ADDR  = addr_q[3];
  assign BLKERS_LOW_ADDR   = addr_q[4];
  assign BLKERS_HIGH_ADDR  = addr_q[5];
  assign PDREAD_LOW_ADDR   = addr_q[6];
  assign PDREAD_HIGH_ADDR  = addr_q[7];
  assign WRSTAT_LOW_ADDR   = addr_q[8];
  assign WRSTAT_HIGH_ADDR  = addr_q[9];

endmodule

// File: tb/tb_ptmch_cfg.sv
// Scoreboard bench for ptmch_cfg: per-bit MISO/strobe expectations are queued as
// frames are driven; a register model is compared after every frame.
module tb_ptmch_cfg;

  localparam logic [3:0] WR = 4'hA;
  localparam logic [3:0] RD = 4'h5;

  logic        RESET_N;
  logic        SPI_CLK;
  logic        CFG_CS_N;
  logic        CFG_MOSI;
  logic        CFG_MISO;
  logic [23:0] addr_o [10];
  logic [4:0]  TRG_EN;
  logic        CFG_WR_STB;
  logic [7:0]  ERR_CNT;

  ptmch_cfg dut (
    .RESET_N           (RESET_N),
    .SPI_CLK           (SPI_CLK),
    .CFG_CS_N          (CFG_CS_N),
    .CFG_MOSI          (CFG_MOSI),
    .CFG_MISO          (CFG_MISO),
    .PRGEXCT_LOW_ADDR  (addr_o[0]),
    .PRGEXCT_HIGH_ADDR (addr_o[1]),
    .RDSTAT_LOW_ADDR   (addr_o[2]),
    .RDSTAT_HIGH_ADDR  (addr_o[3]),
    .BLKERS_LOW_ADDR   (addr_o[4]),
    .BLKERS_HIGH_ADDR  (addr_o[5]),
    .PDREAD_LOW_ADDR   (addr_o[6]),
    .PDREAD_HIGH_ADDR  (addr_o[7]),
    .WRSTAT_LOW_ADDR   (addr_o[8]),
    .WRSTAT_HIGH_ADDR  (addr_o[9]),
    .TRG_EN            (TRG_EN),
    .CFG_WR_STB        (CFG_WR_STB),
    .ERR_CNT           (ERR_CNT)
  );

  initial SPI_CLK = 1'b0;
  always #5 SPI_CLK = ~SPI_CLK;

  typedef struct {
    logic miso;
    logic stb;
  } exp_t;

  exp_t        sb [$];
  logic [23:0] m_addr [10];
  logic [4:0]  m_en;
  logic [7:0]  m_err;
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 10; i++) m_addr[i] = (i % 2 == 0) ? 24'h000000 : 24'hFFFFFF;
    m_en  = 5'h1F;
    m_err = 8'h00;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 10; i++) check($sformatf("%s_addr%0d", tag, i), addr_o[i], m_addr[i]);
    check({tag, "_en"},  TRG_EN,  m_en);
    check({tag, "_err"}, ERR_CNT, m_err);
  endtask

  // Drives nbits of {hdr,data} MSB first (bits past 32 are filler).
  task automatic send_frame(input logic [7:0] hdr, input logic [23:0] data,
                            input int nbits, input int glitch_at);
    logic [31:0] frame;
    logic [3:0]  op;
    logic [3:0]  idx;
    logic        valid;
    logic [23:0] rv;
    exp_t        e;
    frame = {hdr, data};
    op    = hdr[7:4];
    idx   = hdr[3:0];
    valid = (op == WR || op == RD) && idx < 4'd12;
    rv    = (idx < 4'd10) ? m_addr[idx] : (idx == 4'd10) ? {19'd0, m_en} : {16'd0, m_err};
    for (int k = 1; k <= nbits; k++) begin
      e.miso = (op == RD && valid && k >= 8 && k <= 31) ? rv[31-k] : 1'b0;
      e.stb  = (op == WR && valid && k == 32);
      sb.push_back(e);
    end
    for (int k = 1; k <= nbits; k++) begin
      @(negedge SPI_CLK);
      CFG_CS_N = 1'b0;
      CFG_MOSI = (k <= 32) ? frame[32-k] : 1'($urandom_range(0, 1));
      if (k == glitch_at) begin
        #1 CFG_CS_N = 1'b1;
        #1 CFG_CS_N = 1'b0;
      end
      @(posedge SPI_CLK);
      #1;
      if (sb.size() == 0) begin
        check("sb_empty", 1, 0);
      end else begin
        e = sb.pop_front();
        check($sformatf("miso_b%0d", k), CFG_MISO, e.miso);
        check($sformatf("stb_b%0d", k), CFG_WR_STB, e.stb);
      end
    end
    if (nbits >= 8 && !valid && m_err != 8'hFF) m_err++;
    if (nbits >= 32 && valid && op == WR) begin
      if (idx < 4'd10)       m_addr[idx] = data;
      else if (idx == 4'd10) m_en = data[4:0];
      else                   m_err = 8'h00;
    end
    if (nbits >= 1 && nbits <= 31 && m_err != 8'hFF) m_err++;
  endtask

  task automatic end_frame(input string tag, input bit full);
    @(negedge SPI_CLK);
    CFG_CS_N = 1'b1;
    @(posedge SPI_CLK);
    #1;
    check({tag, "_stb_idle"},  CFG_WR_STB, 0);
    check({tag, "_miso_idle"}, CFG_MISO, 0);
    if (full) check_regs(tag);
  endtask

  task automatic frame(input string tag, input logic [7:0] hdr, input logic [23:0] data,
                       input int nbits, input int glitch_at);
    send_frame(hdr, data, nbits, glitch_at);
    end_frame(tag, 1'b1);
  endtask

  initial begin
    RESET_N  = 1'b0;
    CFG_CS_N = 1'b1;
    CFG_MOSI = 1'b0;
    model_reset();
    #12;
    check_regs("rst");
    check("rst_miso", CFG_MISO, 0);
    check("rst_stb",  CFG_WR_STB, 0);
    RESET_N = 1'b1;
    repeat (2) @(negedge SPI_CLK);
    check_regs("post_rst");

    // Write RDSTAT_HIGH with 8 further bits clocked in DONE, then read it back.
    frame("wr_rdstat_hi", 8'hA3, 24'h123456, 40, 0);
    frame("rd_rdstat_hi", 8'h53, 24'h000000, 32, 0);

    // LOW > HIGH accepted unchecked, then read both plus TRG_EN and a default window.
    frame("wr_blk_lo", 8'hA4, 24'hFFFFF0, 32, 0);
    frame("wr_blk_hi", 8'hA5, 24'h00000F, 32, 0);
    frame("rd_blk_lo", 8'h54, 24'h000000, 32, 0);
    frame("rd_blk_hi", 8'h55, 24'h000000, 32, 0);
    frame("rd_en",     8'h5A, 24'h000000, 32, 0);
    frame("rd_wrs_hi", 8'h59, 24'h000000, 32, 0);

    // Bad frames: invalid idx, invalid op, truncated write.
    frame("bad_idx",   8'hAC, 24'h5A5A5A, 32, 0);
    frame("bad_op",    8'h7A, 24'hA5A5A5, 32, 0);
    frame("trunc",     8'hA0, 24'h123000, 20, 0);
    check("err_three", ERR_CNT, 8'h03);
    frame("rd_err",    8'h5B, 24'h000000, 32, 0);

    // Chip-select glitch between edges must not disturb the frame.
    frame("glitch_wr", 8'hA6, 24'hC0FFEE, 32, 16);

    // Saturate the error counter, then clear it with a write to idx 11.
    for (int i = 0; i < 256; i++) begin
      if (i % 2 == 0) send_frame({4'h7, 4'($urandom_range(0, 15))}, 24'($urandom), 32, 0);
      else            send_frame({WR, 4'hC + 4'($urandom_range(0, 3))}, 24'($urandom), 32, 0);
      end_frame("sat", 1'b0);
      check("sat_err", ERR_CNT, m_err);
    end
    check("err_sat", ERR_CNT, 8'hFF);
    frame("err_clr", 8'hAB, 24'h000000, 32, 0);
    check("err_zero", ERR_CNT, 8'h00);

    // Reset asserted mid-frame, between clock edges.
    frame("wr_prg_lo", 8'hA0, 24'h00BEEF, 32, 0);
    send_frame(8'hA0, 24'hABCDEF, 20, 0);
    RESET_N  = 1'b0;
    CFG_CS_N = 1'b1;
    model_reset();
    #2;
    check_regs("mid_rst");
    RESET_N = 1'b1;
    @(posedge SPI_CLK);
    #1;
    check_regs("mid_rst_rel");
    frame("wr_en", 8'hAA, 24'h000005, 32, 0);
    check("en_five", TRG_EN, 5'h05);

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ptmch_cfg.md
PTMCH_CFG -- requirements
Module: ptmch_cfg

Interface
REQ-001 SHALL have parameter P_WR_OP, default 4'hA, the write opcode in header bits [7:4].
REQ-002 SHALL have parameter P_RD_OP, default 4'h5, the read opcode in header bits [7:4].
REQ-003 SHALL have parameter P_LOW_RST, default 24'h000000, the reset value of all *_LOW_ADDR outputs.
REQ-004 SHALL have parameter P_HIGH_RST, default 24'hFFFFFF, the reset value of all *_HIGH_ADDR outputs.
REQ-005 SHALL have parameter P_EN_RST, default 5'h1F, the reset value of TRG_EN.
REQ-006 SHALL have ports: RESET_N  in  1  asynchronous active-low reset; SPI_CLK  in  1  clock, all logic on rising edge.
REQ-007 SHALL have ports: CFG_CS_N  in  1  config chip select, active low, sampled on SPI_CLK; CFG_MOSI  in  1  serial data in, MSB first; CFG_MISO  out  1  registered serial read data.
REQ-008 SHALL have ports: PRGEXCT_LOW_ADDR, PRGEXCT_HIGH_ADDR, RDSTAT_LOW_ADDR, RDSTAT_HIGH_ADDR, BLKERS_LOW_ADDR, BLKERS_HIGH_ADDR, PDREAD_LOW_ADDR, PDREAD_HIGH_ADDR, WRSTAT_LOW_ADDR, WRSTAT_HIGH_ADDR  out  24 each  trigger address windows.
REQ-009 SHALL have ports: TRG_EN  out  5  per-trigger-channel enable; CFG_WR_STB  out  1  one-cycle pulse per committed write; ERR_CNT  out  8  saturating bad-frame count.

Function
REQ-010 A frame SHALL be the bits sampled on consecutive rising edges with CFG_CS_N=0: 8-bit header {op[3:0], idx[3:0]}, then 24 data bits, 32 bits total.
REQ-011 The FSM SHALL have states IDLE, HDR, DATA and DONE; any edge sampling CFG_CS_N=1 SHALL force IDLE and clear the 6-bit bit counter.
REQ-012 IDLE->HDR SHALL occur on the first edge with CFG_CS_N=0, and that bit SHALL be captured as header bit 7.
REQ-013 HDR->DATA SHALL occur on the edge capturing bit 8; DATA->DONE SHALL occur on the edge capturing bit 32; DONE SHALL ignore further bits until CFG_CS_N=1.
REQ-014 Register map: idx 0..9 SHALL be, in order, PRGEXCT_LOW, PRGEXCT_HIGH, RDSTAT_LOW, RDSTAT_HIGH, BLKERS_LOW, BLKERS_HIGH, PDREAD_LOW, PDREAD_HIGH, WRSTAT_LOW, WRSTAT_HIGH; idx 10 SHALL be TRG_EN (data[4:0]); idx 11 SHALL be ERR_CNT (data[7:0]); idx 12..15 SHALL be invalid.
REQ-015 A write (op=P_WR_OP, idx 0..10) SHALL update the target register on the edge capturing bit 32, with the value visible at the output after that edge.
REQ-016 CFG_WR_STB SHALL be 1 for exactly the one cycle following that commit edge.
REQ-017 A write to idx 11 SHALL clear ERR_CNT to 0 at the commit edge, ignoring the data, and SHALL pulse CFG_WR_STB.
REQ-018 A write SHALL be stored unchecked; LOW > HIGH SHALL be accepted as-is.
REQ-019 On a read (op=P_RD_OP, valid idx), the edge capturing header bit 8 SHALL load the selected value, zero-extended to 24 bits, into the output shift register.
REQ-020 On a read, CFG_MISO SHALL equal data[23] after that edge and SHALL advance one bit per edge through data[0] after the edge capturing bit 31.
REQ-021 CFG_MISO SHALL be 0 in IDLE, HDR and DONE, during writes, and during invalid frames.
REQ-022 A read SHALL NOT modify any register.
REQ-023 An invalid header (op not P_WR_OP/P_RD_OP, or idx >= 12) SHALL increment ERR_CNT once at the bit-8 edge, and that frame's data SHALL be discarded.
REQ-024 A frame truncated by CFG_CS_N=1 with the bit counter in 1..31 SHALL increment ERR_CNT once at that edge and SHALL commit no write.
REQ-025 ERR_CNT SHALL saturate at 8'hFF.
REQ-026 A CFG_CS_N high-low toggle with no SPI_CLK edge in between SHALL be invisible; the frame continues.

Reset
REQ-027 RESET_N=0 SHALL asynchronously set FSM=IDLE, bit counter=0, shift registers=0, CFG_MISO=0, CFG_WR_STB=0, ERR_CNT=0, all *_LOW_ADDR=P_LOW_RST, all *_HIGH_ADDR=P_HIGH_RST and TRG_EN=P_EN_RST.
REQ-028 Reset asserted mid-frame SHALL discard the frame with no commit and no ERR_CNT change; after release, the next frame SHALL start from IDLE.

Verification
REQ-029 Reset release -> all LOW=000000, all HIGH=FFFFFF, TRG_EN=1F, ERR_CNT=00, CFG_MISO=0.
REQ-030 Write frame 0xA3_123456 -> RDSTAT_HIGH_ADDR=123456 after bit 32, CFG_WR_STB high 1 cycle, other outputs unchanged; a further 8 clocks in DONE -> no change.
REQ-031 Read frame 0x53 after REQ-030 -> CFG_MISO shifts 0x123456 MSB first, starting after the bit-8 edge.
REQ-032 Frame 0xAC_xxxxxx, frame 0x7A_xxxxxx, and a 20-bit frame 0xA0_123 -> ERR_CNT=03, no register changed, CFG_WR_STB never high.
REQ-033 256 invalid frames -> ERR_CNT=FF and holds; write frame 0xAB_000000 -> ERR_CNT=00.
REQ-034 RESET_N pulsed low at bit 20 of write 0xA0_ABCDEF -> PRGEXCT_LOW_ADDR=000000; next write 0xAA_000005 -> TRG_EN=05.
